// File: rtl/image_receiver_pkg.sv
// Shared types and constants for the FPGA-to-Nano pixel link receivers.
package image_link_pkg;
   localparam int DEF_NUM_PIXELS = 76800;
   localparam int DEF_CLK_FREQ   = 50_000_000;
   localparam logic [7:0] HI_NIBBLE_MASK = 8'hF0;

   typedef logic [11:0] pixel_t;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;
endpackage

// File: rtl/image_receiver_if.sv
// Frame-buffer write port plus status strobes driven by the pixel receiver.
interface image_receiver_if;
   import image_link_pkg::*;

   logic        wr_en;
   logic [16:0] wr_addr;
   pixel_t      wr_data;
   logic        frame_done;
   logic        rx_error;

   modport master (output wr_en, wr_addr, wr_data, frame_done, rx_error);
   modport slave  (input  wr_en, wr_addr, wr_data, frame_done, rx_error);
endinterface

// File: rtl/image_receiver_uart_byte_rx.sv
// 8N1 UART byte receiver with a 2-flop input synchroniser; samples mid-bit.
module uart_byte_rx
   import image_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       framing_err
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   logic rx_p0, rx_p1;
   rx_state_t state, state_nx;
   logic [CW-1:0] clk_cnt, clk_cnt_nx;
   logic [2:0] bit_cnt, bit_cnt_nx;
   logic [7:0] shreg, shreg_nx;
   logic vld_nx, ferr_nx;

   // Stage p0/p1: synchroniser, idles high so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         clk_cnt     <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         byte_valid  <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         state       <= state_nx;
         clk_cnt     <= clk_cnt_nx;
         bit_cnt     <= bit_cnt_nx;
         shreg       <= shreg_nx;
         byte_valid  <= vld_nx;
         framing_err <= ferr_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      clk_cnt_nx = clk_cnt;
      bit_cnt_nx = bit_cnt;
      shreg_nx   = shreg;
      vld_nx     = 1'b0;
      ferr_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_p1) begin
               state_nx   = START;
               clk_cnt_nx = '0;
               bit_cnt_nx = '0;
            end
         end
         START: begin
            if (clk_cnt == HALF_LAST) begin
               clk_cnt_nx = '0;
               state_nx   = rx_p1 ? IDLE : DATA;
            end else begin
               clk_cnt_nx = clk_cnt + CW'(1);
            end
         end
         DATA: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_nx = '0;
               shreg_nx   = {rx_p1, shreg[7:1]};
               bit_cnt_nx = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nx = STOP;
            end else begin
               clk_cnt_nx = clk_cnt + CW'(1);
            end
         end
         STOP: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_nx = '0;
               state_nx   = IDLE;
               vld_nx     = rx_p1;
               ferr_nx    = !rx_p1;
            end else begin
               clk_cnt_nx = clk_cnt + CW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign byte_out = shreg;
endmodule

// File: rtl/image_receiver.sv
// UART pixel receiver: pairs bytes into RGB444 pixels and writes them sequentially.
module image_receiver
   import image_link_pkg::*;
#(
   parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
   parameter int CLK_FREQ    = DEF_CLK_FREQ,
   parameter int BAUD_RATE   = 9600,
   parameter int GAP_TIMEOUT = 16 * (CLK_FREQ / BAUD_RATE)
) (
   input  logic clk,
   input  logic rst,
   input  logic uart_in,
   image_receiver_if.master fb
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int GW = $clog2(GAP_TIMEOUT + 1);
   localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_TIMEOUT);
   localparam logic [16:0]   ADDR_LAST = 17'(NUM_PIXELS - 1);

   logic [7:0] rx_byte;
   logic byte_vld, framing_err;

   uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
      .clk         (clk),
      .rst         (rst),
      .rx          (uart_in),
      .byte_out    (rx_byte),
      .byte_valid  (byte_vld),
      .framing_err (framing_err)
   );

   asm_state_t asm_state, asm_nx;
   logic [3:0] nibble, nibble_nx;
   logic [GW-1:0] gap_cnt, gap_nx;
   logic [16:0] addr, addr_nx;
   logic vld_p1, vld_nx;
   logic [16:0] wr_addr_p1, wr_addr_nx;
   pixel_t wr_data_p1, wr_data_nx;
   logic frame_done_p1, frame_done_nx;
   logic rx_error_p1, rx_error_nx;

   // Stage p1: registered write port, one cycle behind byte_valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm_state     <= WAIT_HI;
         nibble        <= '0;
         gap_cnt       <= '0;
         addr          <= '0;
         vld_p1        <= 1'b0;
         wr_addr_p1    <= '0;
         wr_data_p1    <= '0;
         frame_done_p1 <= 1'b0;
         rx_error_p1   <= 1'b0;
      end else begin
         asm_state     <= asm_nx;
         nibble        <= nibble_nx;
         gap_cnt       <= gap_nx;
         addr          <= addr_nx;
         vld_p1        <= vld_nx;
         wr_addr_p1    <= wr_addr_nx;
         wr_data_p1    <= wr_data_nx;
         frame_done_p1 <= frame_done_nx;
         rx_error_p1   <= rx_error_nx;
      end
   end

   always_comb begin
      asm_nx        = asm_state;
      nibble_nx     = nibble;
      gap_nx        = gap_cnt;
      addr_nx       = addr;
      vld_nx        = 1'b0;
      wr_addr_nx    = wr_addr_p1;
      wr_data_nx    = wr_data_p1;
      frame_done_nx = 1'b0;
      rx_error_nx   = 1'b0;
      if (framing_err) begin
         rx_error_nx = 1'b1;
         asm_nx      = WAIT_HI;
      end else begin
         case (asm_state)
            WAIT_HI: begin
               if (byte_vld) begin
                  if ((rx_byte & HI_NIBBLE_MASK) != 8'h00) begin
                     rx_error_nx = 1'b1;
                  end else begin
                     nibble_nx = rx_byte[3:0];
                     gap_nx    = '0;
                     asm_nx    = WAIT_LO;
                  end
               end
            end
            WAIT_LO: begin
               // A byte arriving on the timeout cycle still wins
               if (byte_vld) begin
                  vld_nx        = 1'b1;
                  wr_addr_nx    = addr;
                  wr_data_nx    = {nibble, rx_byte};
                  frame_done_nx = (addr == ADDR_LAST);
                  addr_nx       = (addr == ADDR_LAST) ? 17'd0 : addr + 17'd1;
                  asm_nx        = WAIT_HI;
               end else if (gap_cnt == GAP_MAX) begin
                  rx_error_nx = 1'b1;
                  asm_nx      = WAIT_HI;
               end else begin
                  gap_nx = gap_cnt + GW'(1);
               end
            end
            default: asm_nx = WAIT_HI;
         endcase
      end
   end

   assign fb.wr_en      = vld_p1;
   assign fb.wr_addr    = wr_addr_p1;
   assign fb.wr_data    = wr_data_p1;
   assign fb.frame_done = frame_done_p1;
   assign fb.rx_error   = rx_error_p1;
endmodule

// File: doc/image_receiver.md
Name: image_receiver

Overview:
- UART receive end of the FPGA-to-Nano pixel link.
- Deserialises the 8N1 byte stream produced by the pixel transmitter and reassembles 12-bit RGB444 pixels from byte pairs.
- Writes pixels sequentially into a frame-buffer write port (address 0..NUM_PIXELS-1) and flags frame completion.
- Used for FPGA-to-FPGA loopback and for the return-image path.

Parameters:
- NUM_PIXELS, 76800 (320*240): pixels per frame; the address wraps after NUM_PIXELS-1.
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division).
- GAP_TIMEOUT, 16*CLKS_PER_BIT: maximum idle clocks allowed between the high and low byte of one pixel.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- uart_in  in  1  serial RX line, idle high, asynchronous to clk
- wr_en  out  1  one-cycle write strobe to the frame buffer
- wr_addr  out  17  pixel address for the current write
- wr_data  out  12  pixel value {R[3:0],G[3:0],B[3:0]}
- frame_done  out  1  one-cycle pulse coincident with the write of pixel NUM_PIXELS-1
- rx_error  out  1  one-cycle pulse on a framing, protocol or timeout error

Behaviour:
- Reset (async, rst=1):
  - wr_en=0, wr_addr=0, wr_data=0, frame_done=0, rx_error=0.
  - Synchroniser flops preset to 1.
  - Byte RX state=IDLE; assembler state=WAIT_HI.
  - Reset mid-byte or mid-pixel discards the partial data; no write occurs.
- Input path: 2-flop synchroniser on uart_in. All logic uses the synchronised signal (2-cycle input latency).
- Byte RX FSM:
  - IDLE: a falling edge (synchronised line = 0) -> START, bit counter cleared.
  - START: wait CLKS_PER_BIT/2 clocks, then sample. If 0 -> DATA. If 1 (glitch) -> IDLE, no error.
  - DATA: sample every CLKS_PER_BIT clocks, LSB first, 8 bits -> STOP.
  - STOP: sample after CLKS_PER_BIT. If 1 -> emit byte_valid for one cycle with byte. If 0 -> emit framing_err for one cycle and no byte. Then -> IDLE.
- Pixel assembler FSM (byte framing: byte0 = {4'h0, pixel[11:8]}, byte1 = pixel[7:0]):
  - WAIT_HI, byte_valid:
    - If byte[7:4] != 0: drop the byte, pulse rx_error, stay in WAIT_HI.
    - Otherwise: latch the nibble, clear the gap counter, go to WAIT_LO.
  - WAIT_LO, byte_valid: the following cycle asserts wr_en=1 with wr_data={nibble,byte} and wr_addr=current address. The address increments after the write, then return to WAIT_HI.
  - WAIT_LO, gap counter reaches GAP_TIMEOUT before byte_valid: pulse rx_error, discard the nibble, return to WAIT_HI.
  - framing_err in any state: pulse rx_error. In WAIT_LO, discard the nibble and return to WAIT_HI.
- Write latency: wr_en asserts 1 cycle after byte_valid. wr_addr and wr_data are stable while wr_en=1 and hold their last values otherwise.
- Wrap-around: when a write uses wr_addr = NUM_PIXELS-1, frame_done=1 in the same cycle. The address becomes 0 for the next write.
- Simultaneous events: a timeout and byte_valid in the same cycle resolve in favour of the byte (the write occurs, no error). rx_error and frame_done are independent and may coincide.
- Width rules: the address counter is 17 bits and compares to NUM_PIXELS-1. The gap counter is sized by $clog2(GAP_TIMEOUT+1) and saturates at GAP_TIMEOUT.

Decomposition:
- Package image_link_pkg holds:
  - NUM_PIXELS and CLK_FREQ defaults.
  - Typedef pixel_t (logic [11:0]).
  - Enum rx_state_t {IDLE, START, DATA, STOP}.
  - Enum asm_state_t {WAIT_HI, WAIT_LO}.
  - Byte-framing constant HI_NIBBLE_MASK = 8'hF0.
- One sub-module: uart_byte_rx (synchroniser + byte RX FSM; ports clk, rst, rx, byte_out[7:0], byte_valid, framing_err), reused by other receivers.
- image_receiver instantiates uart_byte_rx and contains the pixel assembler.

Test Plan (CLK_FREQ=1000, BAUD_RATE=100 -> CLKS_PER_BIT=10; NUM_PIXELS=4; GAP_TIMEOUT=160):
- Bytes 0x0A, 0xBC -> single wr_en with wr_addr=0, wr_data=12'hABC, 1 cycle after the stop bit of 0xBC. No rx_error.
- 4 pixels 0x123, 0x456, 0x789, 0xFED -> writes at addresses 0,1,2,3. frame_done high only with address 3. A 5th pixel 0x001 writes at address 0.
- Byte 0x5A as the high byte -> rx_error pulse, no write. Then 0x03, 0x21 -> write 12'h321 at the next address.
- 0x07, then idle for 200 clocks, then 0x0F, 0x00 -> rx_error at clock 160 of the gap, partial 0x7 discarded. Single write 12'hF00.
- Byte with stop bit forced 0 in WAIT_LO -> rx_error, no write. The assembler is back in WAIT_HI, and the next pair 0x01, 0x11 writes 12'h111.
- Assert rst mid-DATA of the low byte -> all outputs 0 immediately (async). After release, pair 0x0C, 0xCC writes 12'hCCC at address 0. A 3-clock low glitch on uart_in produces no byte and no error.
